data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/mem_pkg.sv | 17 +
 rtl/mux.sv | 31 +++
 rtl/data_memory.sv | 179 +++++++++++++++++
 tb/tb_data_memory.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types for the data memory block. Holds the dump
//                state machine encoding used by data_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Dump streaming state machine: idle, or presenting one word per beat.
    typedef enum logic [0:0] {
        DMP_IDLE = 1'b0,
        DMP_SEND = 1'b1
    } dmp_state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
//  Module      : mux
//  Description : Generic N-input one-hot-free word multiplexer. Selects word
//                i_sel out of a flat input bus; an out-of-range select gives 0.
//  Ports       : i_data [NUM_INPUTS*WIDTH] flat inputs, word k at k*WIDTH
//                i_sel  [SEL_W]            word select
//                o_data [WIDTH]            selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module mux #(
    parameter int NUM_INPUTS = 2,
    parameter int WIDTH      = 32,
    localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]            i_sel,
    output logic [WIDTH-1:0]            o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(i_sel) == k) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Register-based data memory with flat read-out, a single
//                store port and a ready/valid dump streamer that walks every
//                word in address order.
//  Ports       : clk, rst (synchronous, active-low)
//                i_store_enable / i_store_select / i_store_word : store port
//                o_mem          : flat contents, word k at k*REG_WIDTH
//                i_dump_start   : one-cycle request to stream all words
//                o_dump_valid / i_dump_ready : dump handshake
//                o_dump_addr / o_dump_word   : presented dump beat
//                o_dump_busy    : dump in progress
//                o_store_oob    : sticky out-of-range store flag
//                o_store_count  : accepted-store counter (saturating)
//  Config      : DATA_MEMORY_STORE_COUNT_EN - enables o_store_count; when
//                undefined the counter is absent and the port reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import mem_pkg::*;
#(
    parameter int NUM_MEM    = 16,
    parameter int REG_WIDTH  = 32,
    localparam int MEM_SELECT = $clog2(NUM_MEM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_store_enable,
    input  logic [MEM_SELECT-1:0]        i_store_select,
    input  logic [REG_WIDTH-1:0]         i_store_word,
    output logic [NUM_MEM*REG_WIDTH-1:0] o_mem,
    input  logic                         i_dump_start,
    output logic                         o_dump_valid,
    input  logic                         i_dump_ready,
    output logic [MEM_SELECT-1:0]        o_dump_addr,
    output logic [REG_WIDTH-1:0]         o_dump_word,
    output logic                         o_dump_busy,
    output logic                         o_store_oob,
    output logic [15:0]                  o_store_count
);

    // One extra bit so NUM_MEM itself is representable for the range check.
    localparam logic [MEM_SELECT:0]   c_num_mem  = (MEM_SELECT+1)'(NUM_MEM);
    localparam logic [MEM_SELECT-1:0] c_last_adr = MEM_SELECT'(NUM_MEM - 1);

    logic [NUM_MEM-1:0][REG_WIDTH-1:0] r_mem;
    logic                              r_store_oob;
    dmp_state_e                        r_state;
    dmp_state_e                        w_state_nxt;
    logic [MEM_SELECT-1:0]             r_dump_addr;
    logic [MEM_SELECT-1:0]             w_dump_addr_nxt;
    logic [MEM_SELECT-1:0]             w_load_addr;
    logic [REG_WIDTH-1:0]              r_dump_word;
    logic [REG_WIDTH-1:0]              w_dump_word_nxt;
    logic [REG_WIDTH-1:0]              w_mux_word;
    logic                              w_load;
    logic                              w_store_accept;

    assign w_store_accept = i_store_enable && ({1'b0, i_store_select} < c_num_mem);

    // ------------------------------------------------------------------
    // Storage and sticky out-of-range flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem       <= '0;
            r_store_oob <= 1'b0;
        end else begin
            if (w_store_accept) begin
                r_mem[i_store_select] <= i_store_word;
            end
            if (i_store_enable && !w_store_accept) begin
                r_store_oob <= 1'b1;
            end
        end
    end

    assign o_mem       = r_mem;
    assign o_store_oob = r_store_oob;

    // ------------------------------------------------------------------
    // Dump word selection from the pre-edge memory contents
    // ------------------------------------------------------------------
    mux #(
        .NUM_INPUTS (NUM_MEM),
        .WIDTH      (REG_WIDTH)
    ) u_dump_mux (
        .i_data (r_mem),
        .i_sel  (w_load_addr),
        .o_data (w_mux_word)
    );

    // ------------------------------------------------------------------
    // Dump FSM: next state, address and word
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_dump_addr_nxt = r_dump_addr;
        w_load_addr     = '0;
        w_load          = 1'b0;
        case (r_state)
            DMP_IDLE: begin
                if (i_dump_start) begin
                    w_state_nxt     = DMP_SEND;
                    w_dump_addr_nxt = '0;
                    w_load_addr     = '0;
                    w_load          = 1'b1;
                end
            end
            DMP_SEND: begin
                // o_dump_valid is 1 throughout SEND, so ready alone completes a beat.
                if (i_dump_ready) begin
                    if (r_dump_addr == c_last_adr) begin
                        w_state_nxt     = DMP_IDLE;
                        w_dump_addr_nxt = '0;
                    end else begin
                        w_dump_addr_nxt = r_dump_addr + MEM_SELECT'(1);
                        w_load_addr     = r_dump_addr + MEM_SELECT'(1);
                        w_load          = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = DMP_IDLE;
                w_dump_addr_nxt = '0;
            end
        endcase

        // The mux sees memory before this edge's store lands, so a store to
        // the word being loaded is forwarded to keep the beat current.
        w_dump_word_nxt = r_dump_word;
        if (w_load) begin
            if (w_store_accept && (i_store_select == w_load_addr)) begin
                w_dump_word_nxt = i_store_word;
            end else begin
                w_dump_word_nxt = w_mux_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= DMP_IDLE;
            r_dump_addr <= '0;
            r_dump_word <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dump_addr <= w_dump_addr_nxt;
            r_dump_word <= w_dump_word_nxt;
        end
    end

    assign o_dump_valid = (r_state == DMP_SEND);
    assign o_dump_busy  = (r_state != DMP_IDLE);
    assign o_dump_addr  = r_dump_addr;
    assign o_dump_word  = r_dump_word;

    // ------------------------------------------------------------------
    // Accepted-store counter
    // ------------------------------------------------------------------
`ifdef DATA_MEMORY_STORE_COUNT_EN
    logic [15:0] r_store_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_store_count <= 16'd0;
        end else if (w_store_accept && (r_store_count != 16'hFFFF)) begin
            r_store_count <= r_store_count + 16'd1;
        end
    end

    assign o_store_count = r_store_count;
`else
    assign o_store_count = 16'd0;
`endif

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Directed self-checking bench for data_memory (16 words and a
//                12-word instance for out-of-range stores). Honours
//                DATA_MEMORY_STORE_COUNT_EN for counter expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

`ifdef DATA_MEMORY_STORE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_en;
    logic [3:0]   s_sel;
    logic [31:0]  s_word;
    logic         start;
    logic         ready;
    logic [511:0] mem;
    logic         dvalid;
    logic [3:0]   daddr;
    logic [31:0]  dword;
    logic         busy;
    logic         oob;
    logic [15:0]  cnt;

    logic         s12_en;
    logic [3:0]   s12_sel;
    logic [31:0]  s12_word;
    logic         start12;
    logic         ready12;
    logic [383:0] mem12;
    logic         dvalid12;
    logic [3:0]   daddr12;
    logic [31:0]  dword12;
    logic         busy12;
    logic         oob12;
    logic [15:0]  cnt12;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl   [16];
    logic [31:0] mdl12 [12];

    always #5 clk = ~clk;

    data_memory #(.NUM_MEM(16), .REG_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_store_enable(s_en), .i_store_select(s_sel), .i_store_word(s_word),
        .o_mem(mem), .i_dump_start(start), .o_dump_valid(dvalid),
        .i_dump_ready(ready), .o_dump_addr(daddr), .o_dump_word(dword),
        .o_dump_busy(busy), .o_store_oob(oob), .o_store_count(cnt)
    );

    data_memory #(.NUM_MEM(12), .REG_WIDTH(32)) dut12 (
        .clk(clk), .rst(rst),
        .i_store_enable(s12_en), .i_store_select(s12_sel), .i_store_word(s12_word),
        .o_mem(mem12), .i_dump_start(start12), .o_dump_valid(dvalid12),
        .i_dump_ready(ready12), .o_dump_addr(daddr12), .o_dump_word(dword12),
        .o_dump_busy(busy12), .o_store_oob(oob12), .o_store_count(cnt12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] flat();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = mdl[k];
        return v;
    endfunction

    function automatic logic [383:0] flat12();
        logic [383:0] v;
        for (int k = 0; k < 12; k++) v[k*32 +: 32] = mdl12[k];
        return v;
    endfunction

    task automatic clear_models();
        for (int k = 0; k < 16; k++) mdl[k] = 32'd0;
        for (int k = 0; k < 12; k++) mdl12[k] = 32'd0;
    endtask

    task automatic store(input int a, input logic [31:0] d);
        s_en = 1'b1; s_sel = a[3:0]; s_word = d;
        tick();
        s_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic store12(input int a, input logic [31:0] d);
        s12_en = 1'b1; s12_sel = a[3:0]; s12_word = d;
        tick();
        s12_en = 1'b0;
        if (a < 12) mdl12[a] = d;
    endtask

    // Full dump with a reference model. toggle: ready goes 1,0,1,0...
    // One store of st_data to st_addr is injected: while stalled on that
    // address (toggle mode) or on the beat that loads it (streaming mode).
    // A start pulse is also given mid-dump; it must be ignored.
    task automatic dump_run(input string tag, input bit toggle, input int st_addr,
                            input logic [31:0] st_data);
        int          a;
        logic [31:0] w;
        bit          done;
        bit          stored;
        bit          fire;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 0; w = mdl[0]; done = 1'b0; stored = 1'b0;
        check({tag, "_first_valid"}, dvalid, 1'b1);
        check({tag, "_first_addr"}, daddr, 0);
        check({tag, "_first_word"}, dword, w);
        for (int c = 0; c < 80 && !done; c++) begin
            ready = toggle ? (c % 2 == 0) : 1'b1;
            start = (c == 3);
            fire  = !stored && (toggle ? (!ready && a == st_addr)
                                       : (ready && a == st_addr - 1));
            if (fire) begin
                s_en = 1'b1; s_sel = st_addr[3:0]; s_word = st_data;
                stored = 1'b1;
            end
            tick();
            s_en  = 1'b0;
            start = 1'b0;
            if (fire) mdl[st_addr] = st_data;
            if (ready) begin
                if (a == 15) done = 1'b1;
                else begin
                    a++;
                    w = mdl[a];
                end
            end
            check({tag, "_valid"}, dvalid, !done);
            if (!done) begin
                check({tag, "_addr"}, daddr, a);
                check({tag, "_word"}, dword, w);
            end
        end
        ready = 1'b0;
        check({tag, "_completed"}, done, 1'b1);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_addr_end"}, daddr, 0);
    endtask

    initial begin
        rst = 1'b0; s_en = 1'b0; s_sel = '0; s_word = '0; start = 1'b0; ready = 1'b0;
        s12_en = 1'b0; s12_sel = '0; s12_word = '0; start12 = 1'b0; ready12 = 1'b0;
        clear_models();

        // Reset state
        tick(); tick();
        check("rst_mem", mem, 512'd0);
        check("rst_valid", dvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", daddr, 0);
        check("rst_word", dword, 0);
        check("rst_oob", oob, 1'b0);
        check("rst_cnt", cnt, 0);
        check("rst_oob12", oob12, 1'b0);

        // Single store
        rst = 1'b1;
        store(3, 32'hDEADBEEF);
        check("st3_mem", mem, flat());
        check("st3_word3", mem[3*32 +: 32], 32'hDEADBEEF);
        check("st3_cnt", cnt, CNT_EN ? 16'd1 : 16'd0);

        // Reset wins over a simultaneous store
        rst = 1'b0;
        store(5, 32'h12345678);
        rst = 1'b1;
        clear_models();
        check("rstprio_mem", mem, 512'd0);
        check("rstprio_cnt", cnt, 0);

        // Out-of-range store on the 12-word instance
        store12(2, 32'h22);
        check("oob_pre_mem", mem12, flat12());
        check("oob_pre_flag", oob12, 1'b0);
        store12(13, 32'hBAD);
        check("oob_mem", mem12, flat12());
        check("oob_flag", oob12, 1'b1);
        check("oob_cnt", cnt12, CNT_EN ? 16'd1 : 16'd0);
        store12(4, 32'h44);
        check("oob_post_mem", mem12, flat12());
        check("oob_sticky", oob12, 1'b1);
        check("oob_post_cnt", cnt12, CNT_EN ? 16'd2 : 16'd0);

        // Preload k+100 and stream with ready held high
        for (int k = 0; k < 16; k++) store(k, 32'(k + 100));
        check("preload_mem", mem, flat());
        dump_run("d1", 1'b0, -1, 32'd0);

        // Toggled ready; store 0x55 to address 6 while stalled on it
        dump_run("d2", 1'b1, 6, 32'h55);
        check("d2_mem", mem, flat());
        // Re-dump sees 0x55; store to 9 coincides with loading 9 (forwarded)
        dump_run("d3", 1'b0, 9, 32'h99);
        check("d3_mem", mem, flat());

        // Reset at beat 5
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rb_addr5", daddr, 5);
        check("rb_valid5", dvalid, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_models();
        check("rb_valid", dvalid, 1'b0);
        check("rb_busy", busy, 1'b0);
        check("rb_mem", mem, 512'd0);
        check("rb_addr", daddr, 0);
        tick();
        check("rb_idle", dvalid, 1'b0);
        ready = 1'b0;
        dump_run("d4", 1'b0, -1, 32'd0);

        // Counter saturation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        s_en = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            s_sel = 4'(i);
            s_word = 32'(i);
            tick();
        end
        s_en = 1'b0;
        check("sat_cnt", cnt, CNT_EN ? 16'hFFFF : 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_memory
`default_nettype wire
